// File: rtl/maze_move_checker.sv
// maze_move_checker: validates a one-pixel player step by reading back the
// leading edge of the sprite from the frame source. It owns the committed
// player position.
`timescale 1ns/1ps
module maze_move_checker #(
  parameter int unsigned FRAME_W = 96,
  parameter int unsigned FRAME_H = 64,
  parameter int unsigned SPRITE  = 9,
  parameter logic [15:0] WALL    = 16'hFFFF,
  parameter int unsigned INIT_X  = 3,
  parameter int unsigned INIT_Y  = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        move_req,
  input  logic [1:0]  dir,
  output logic [12:0] index,
  input  logic [15:0] data,
  output logic [6:0]  pos_x,
  output logic [5:0]  pos_y,
  output logic        busy,
  output logic        done,
  output logic        blocked
);

  localparam int unsigned XW = 7;
  localparam int unsigned YW = 6;
  localparam int unsigned IW = 13;
  localparam int unsigned KW = 4;
  localparam int unsigned BW = 10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_BOUND,
    S_SCAN,
    S_DRAIN,
    S_FINISH
  } state_t;

  state_t               r_state;
  logic [1:0]           r_dir;
  logic signed [XW:0]   r_cx;
  logic signed [YW:0]   r_cy;
  logic [KW-1:0]        r_k;
  logic                 r_hit;

  logic signed [XW:0]   w_cand_x;
  logic signed [YW:0]   w_cand_y;
  logic signed [BW-1:0] w_cx_e;
  logic signed [BW-1:0] w_cy_e;
  logic                 w_oob;
  logic [KW-1:0]        w_k;
  logic [XW-1:0]        w_px;
  logic [YW-1:0]        w_py;
  logic [IW-1:0]        w_addr;
  logic                 w_wall;

  // Candidate position: current position shifted one pixel in the requested direction.
  always_comb begin
    w_cand_x = $signed({1'b0, pos_x});
    w_cand_y = $signed({1'b0, pos_y});
    case (dir)
      2'd0:    w_cand_y = $signed({1'b0, pos_y}) - 7'sd1;
      2'd1:    w_cand_y = $signed({1'b0, pos_y}) + 7'sd1;
      2'd2:    w_cand_x = $signed({1'b0, pos_x}) - 8'sd1;
      default: w_cand_x = $signed({1'b0, pos_x}) + 8'sd1;
    endcase
  end

  // Frame bounds test on the latched candidate, widened so cy+SPRITE cannot overflow.
  always_comb begin
    w_cx_e = BW'(r_cx);
    w_cy_e = BW'(r_cy);
    w_oob  = (w_cx_e < 10'sd0) || (w_cy_e < 10'sd0) ||
             ((w_cx_e + $signed(BW'(SPRITE))) > $signed(BW'(FRAME_W))) ||
             ((w_cy_e + $signed(BW'(SPRITE))) > $signed(BW'(FRAME_H)));
  end

  // Leading-edge pixel k of the candidate square and its linear frame index.
  always_comb begin
    w_k  = (r_state == S_SCAN) ? r_k : '0;
    w_px = XW'(r_cx);
    w_py = YW'(r_cy);
    case (r_dir)
      2'd0: begin
        w_px = XW'(r_cx) + XW'(w_k);
        w_py = YW'(r_cy);
      end
      2'd1: begin
        w_px = XW'(r_cx) + XW'(w_k);
        w_py = YW'(r_cy) + YW'(SPRITE - 1);
      end
      2'd2: begin
        w_px = XW'(r_cx);
        w_py = YW'(r_cy) + YW'(w_k);
      end
      default: begin
        w_px = XW'(r_cx) + XW'(SPRITE - 1);
        w_py = YW'(r_cy) + YW'(w_k);
      end
    endcase
    w_addr = IW'(w_py) * IW'(FRAME_W) + IW'(w_px);
    w_wall = (data == WALL);
  end

  // Check sequencer: bounds test, full leading-edge scan, drain of last word, commit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_dir   <= 2'd0;
      r_cx    <= '0;
      r_cy    <= '0;
      r_k     <= '0;
      r_hit   <= 1'b0;
      index   <= '0;
      pos_x   <= XW'(INIT_X);
      pos_y   <= YW'(INIT_Y);
      busy    <= 1'b0;
      done    <= 1'b0;
      blocked <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (move_req) begin
            r_dir   <= dir;
            r_cx    <= w_cand_x;
            r_cy    <= w_cand_y;
            busy    <= 1'b1;
            r_state <= S_BOUND;
          end
        end
        S_BOUND: begin
          if (w_oob) begin
            r_hit   <= 1'b1;
            r_state <= S_FINISH;
          end else begin
            r_hit   <= 1'b0;
            index   <= w_addr;
            r_k     <= KW'(1);
            r_state <= S_SCAN;
          end
        end
        S_SCAN: begin
          // data lags index by one cycle, so the first scan cycle has nothing to compare yet
          if (r_k != KW'(1)) begin
            r_hit <= r_hit | w_wall;
          end
          if (r_k == KW'(SPRITE)) begin
            r_state <= S_DRAIN;
          end else begin
            index <= w_addr;
            r_k   <= r_k + KW'(1);
          end
        end
        S_DRAIN: begin
          r_hit   <= r_hit | w_wall;
          r_state <= S_FINISH;
        end
        S_FINISH: begin
          done    <= 1'b1;
          blocked <= r_hit;
          if (!r_hit) begin
            pos_x <= XW'(r_cx);
            pos_y <= YW'(r_cy);
          end
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_maze_move_checker.sv
// Scoreboard bench for maze_move_checker with a registered frame-memory model.
`timescale 1ns/1ps
module tb_maze_move_checker;

  logic        clk = 1'b0;
  logic        reset;
  logic        move_req;
  logic [1:0]  dir;
  logic [12:0] index;
  logic [15:0] data;
  logic [6:0]  pos_x;
  logic [5:0]  pos_y;
  logic        busy;
  logic        done;
  logic        blocked;

  maze_move_checker dut (
    .clk(clk), .reset(reset), .move_req(move_req), .dir(dir),
    .index(index), .data(data), .pos_x(pos_x), .pos_y(pos_y),
    .busy(busy), .done(done), .blocked(blocked)
  );

  always #5 clk = ~clk;

  // Frame source: word for the presented index appears one clock later.
  logic [15:0] mem [0:6143];
  always @(posedge clk) data <= mem[index];

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [31:0]       issue;
    logic              blk;
    logic              oob;
    logic [6:0]        ex;
    logic [5:0]        ey;
    logic [12:0]       prev;
    logic [8:0][12:0]  idx;
  } exp_t;

  exp_t        expq[$];
  logic [12:0] obs[$];
  exp_t        mon_e;

  int          mx, my;
  logic [12:0] last_idx;

  task automatic check(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: gathers indices seen while busy and scores each done pulse.
  always @(negedge clk) begin
    if (reset) begin
      obs.delete();
    end else begin
      if (busy) obs.push_back(index);
      if (done) begin
        if (expq.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          mon_e = expq.pop_front();
          check("latency", int'(cyc - mon_e.issue), mon_e.oob ? 3 : 13);
          check("blocked", int'(blocked), int'(mon_e.blk));
          check("pos_x", int'(pos_x), int'(mon_e.ex));
          check("pos_y", int'(pos_y), int'(mon_e.ey));
          check("busy_cycles", obs.size(), mon_e.oob ? 2 : 12);
          if (obs.size() > 0) check("held_index", int'(obs[0]), int'(mon_e.prev));
          if (mon_e.oob && obs.size() >= 2)
            check("oob_index", int'(obs[1]), int'(mon_e.prev));
          if (!mon_e.oob && obs.size() >= 10)
            for (int k = 0; k < 9; k++)
              check("scan_index", int'(obs[k+1]), int'(mon_e.idx[k]));
        end
        obs.delete();
      end
    end
  end

  task automatic check_reset_values();
    check("rst_index", int'(index), 0);
    check("rst_pos_x", int'(pos_x), 3);
    check("rst_pos_y", int'(pos_y), 3);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_blocked", int'(blocked), 0);
  endtask

  task automatic reset_dut();
    @(negedge clk);
    #1 reset = 1'b1;
    #1 check_reset_values();
    mx = 3; my = 3; last_idx = '0;
    expq.delete();
    @(negedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 6144; i++) mem[i] = 16'h0000;
  endtask

  // Predicts the outcome of a step from the game rules, then issues it.
  task automatic issue_move(input logic [1:0] d, input bit pulses);
    exp_t e;
    int   cx, cy, x, y;
    bit   hit;
    int   n;
    cx = mx; cy = my;
    case (d)
      2'd0: cy = my - 1;
      2'd1: cy = my + 1;
      2'd2: cx = mx - 1;
      default: cx = mx + 1;
    endcase
    e = '0;
    e.oob = (cx < 0) || (cy < 0) || (cx + 9 > 96) || (cy + 9 > 64);
    hit = e.oob;
    if (!e.oob) begin
      for (int k = 0; k < 9; k++) begin
        case (d)
          2'd0: begin x = cx + k; y = cy;     end
          2'd1: begin x = cx + k; y = cy + 8; end
          2'd2: begin x = cx;     y = cy + k; end
          default: begin x = cx + 8; y = cy + k; end
        endcase
        e.idx[k] = 13'(y * 96 + x);
        if (mem[y * 96 + x] == 16'hFFFF) hit = 1'b1;
      end
    end
    e.blk = hit;
    if (!hit) begin mx = cx; my = cy; end
    e.ex = 7'(mx);
    e.ey = 6'(my);
    e.prev = last_idx;
    if (!e.oob) last_idx = e.idx[8];

    @(negedge clk);
    move_req = 1'b1;
    dir = d;
    e.issue = cyc;
    expq.push_back(e);
    @(negedge clk);
    move_req = 1'b0;
    if (pulses && !e.oob) begin
      @(negedge clk); move_req = 1'b1; dir = ~d;
      @(negedge clk); move_req = 1'b0;
      @(negedge clk);
      @(negedge clk); move_req = 1'b1; dir = d ^ 2'd1;
      @(negedge clk); move_req = 1'b0;
    end
    n = 0;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      check("done_timeout", 0, 1);
      expq.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, fails);
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    move_req = 1'b0;
    dir = 2'd0;
    mx = 3; my = 3; last_idx = '0;
    clear_mem();
    repeat (2) @(negedge clk);
    reset_dut();

    // Empty frame, step right.
    issue_move(2'd3, 1'b0);

    // Wall in the middle of the right edge.
    reset_dut();
    mem[684] = 16'hFFFF;
    issue_move(2'd3, 1'b0);
    mem[684] = 16'h0000;

    // Near-wall colour is passable.
    mem[684] = 16'hFFFE;
    issue_move(2'd3, 1'b0);
    mem[684] = 16'h0000;

    // Wall only at the last scanned pixel of a downward step.
    reset_dut();
    mem[1163] = 16'hFFFF;
    issue_move(2'd1, 1'b0);
    mem[1163] = 16'h0000;

    // Requests during an active check are ignored.
    reset_dut();
    issue_move(2'd1, 1'b1);
    issue_move(2'd3, 1'b1);

    // Reset during the scan aborts it without a done pulse.
    reset_dut();
    @(negedge clk);
    move_req = 1'b1; dir = 2'd3;
    @(negedge clk);
    move_req = 1'b0;
    repeat (4) @(negedge clk);
    check("busy_mid_scan", int'(busy), 1);
    #1 reset = 1'b1;
    #1 check_reset_values();
    mx = 3; my = 3; last_idx = '0;
    expq.delete();
    repeat (2) @(negedge clk);
    #1 reset = 1'b0;
    repeat (20) @(negedge clk);
    issue_move(2'd3, 1'b0);

    // Walk to the right and top edges, then out of bounds on each.
    reset_dut();
    for (int i = 0; i < 85; i++) issue_move(2'd3, 1'b0);
    for (int i = 0; i < 4; i++) issue_move(2'd0, 1'b0);
    // Walk to the bottom and left edges, then out of bounds on each.
    reset_dut();
    for (int i = 0; i < 53; i++) issue_move(2'd1, 1'b0);
    for (int i = 0; i < 4; i++) issue_move(2'd2, 1'b0);

    // Random maze with random steps.
    for (int i = 0; i < 6144; i++) begin
      int r;
      r = int'($urandom_range(0, 19));
      if (r == 0)      mem[i] = 16'hFFFF;
      else if (r == 1) mem[i] = 16'hFFFE;
      else if (r == 2) mem[i] = 16'h7FFF;
      else             mem[i] = 16'($urandom_range(0, 16'hFFFE));
    end
    reset_dut();
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 3) == 0)
        mem[$urandom_range(0, 6143)] = ($urandom_range(0, 1) == 0) ? 16'hFFFF : 16'h0000;
      issue_move(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (5) @(negedge clk);
    check("pending_expectations", expq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
